// File: rtl/serial_add_sub_seq_if.sv
// Start/done handshake, operand and result bundle for the bit-serial add/subtract sequencer.
interface serial_add_sub_seq_if #(parameter int WIDTH = 64);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, flag_n, flag_z, flag_c, flag_v
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, flag_n, flag_z, flag_c, flag_v
    );
endinterface

// File: rtl/serial_add_sub_seq.sv
// Bit-serial add/subtract: one 1-bit slice, LSB first, WIDTH+1 cycles per operation.
// N/Z/C/V flags are built only when SERIAL_ADDSUB_FLAGS_EN is defined; otherwise they read 0.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one bit pair per clock through the slice
//   DONE  | result/flags valid, done pulse; start here chains the next operation
module serial_add_sub_seq #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_add_sub_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] op_a, op_b, sum_sr, result_q;
    logic             op_sub, carry, accept, last_bit;
    logic             slice_b, slice_sum, slice_cout;

    assign last_bit   = (cnt == CNT_W'(WIDTH - 1));

    // Subtract inverts B inside the slice; the +1 comes from the carry preset at accept.
    assign slice_b    = op_b[0] ^ op_sub;
    assign slice_sum  = op_a[0] ^ slice_b ^ carry;
    assign slice_cout = (op_a[0] & slice_b) | (carry & (op_a[0] ^ slice_b));

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                accept    = 1'b1;
                state_nxt = RUN;
            end
            RUN:  if (last_bit) state_nxt = DONE;
            DONE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_sub   <= 1'b0;
            carry    <= 1'b0;
            sum_sr   <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_a   <= bus.a;
            op_b   <= bus.b;
            op_sub <= bus.sub;
            carry  <= bus.sub;
            cnt    <= '0;
        end else if (state == RUN) begin
            sum_sr <= {slice_sum, sum_sr[WIDTH-1:1]};
            op_a   <= {1'b0, op_a[WIDTH-1:1]};
            op_b   <= {1'b0, op_b[WIDTH-1:1]};
            carry  <= slice_cout;
            if (last_bit) result_q <= {slice_sum, sum_sr[WIDTH-1:1]};
            else          cnt      <= cnt + 1'b1;
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;

`ifdef SERIAL_ADDSUB_FLAGS_EN
    logic any_one, cin_msb, c_q, z_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            any_one <= 1'b0;
            cin_msb <= 1'b0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else if (accept) begin
            any_one <= 1'b0;
        end else if (state == RUN) begin
            any_one <= any_one | slice_sum;
            if (last_bit) begin
                cin_msb <= carry;
                c_q     <= slice_cout;
                z_q     <= ~(any_one | slice_sum);
            end
        end
    end

    assign bus.flag_n = result_q[WIDTH-1];
    assign bus.flag_z = z_q;
    assign bus.flag_c = c_q;
    assign bus.flag_v = cin_msb ^ c_q;
`else
    assign bus.flag_n = 1'b0;
    assign bus.flag_z = 1'b0;
    assign bus.flag_c = 1'b0;
    assign bus.flag_v = 1'b0;
`endif
endmodule

// File: tb/tb_serial_add_sub_seq.sv
// Directed bench for serial_add_sub_seq (WIDTH=64); flag expectations follow SERIAL_ADDSUB_FLAGS_EN.
module tb_serial_add_sub_seq;
    localparam int W = 64;
`ifdef SERIAL_ADDSUB_FLAGS_EN
    localparam logic [3:0] FMASK = 4'hF;
`else
    localparam logic [3:0] FMASK = 4'h0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    serial_add_sub_seq_if #(.WIDTH(W)) bus ();
    serial_add_sub_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [3:0] flags;
    assign flags = {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};

    // Drives one start pulse, then counts edges until done; returns at the done cycle (+1).
    task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic sub_v,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        bus.a = a_v; bus.b = b_v; bus.sub = sub_v; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_cnt = bus.busy ? 1 : 0;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin lat = i; break; end
            if (bus.busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_checks++; if (bus.result !== '0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        n_checks++; if (flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", flags); end
        @(negedge clk); reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if ({bus.busy, bus.done} !== 2'b00) begin n_fail++; $display("FAIL idle_hold busy/done got=%b exp=00", {bus.busy, bus.done}); end
    endtask

    task automatic test_add();
        int lat, bc;
        run_op(64'd5, 64'd3, 1'b0, lat, bc);
        n_checks++; if (lat !== 64) begin n_fail++; $display("FAIL add_latency got=%0d exp=64", lat); end
        n_checks++; if (bc !== 64) begin n_fail++; $display("FAIL add_busy_cycles got=%0d exp=64", bc); end
        n_checks++; if (bus.result !== 64'd8) begin n_fail++; $display("FAIL add_result got=%h exp=8", bus.result); end
        n_checks++; if (flags !== (4'b0000 & FMASK)) begin n_fail++; $display("FAIL add_flags got=%b exp=%b", flags, 4'b0000 & FMASK); end
        @(posedge clk); #1;
        n_checks++; if ({bus.busy, bus.done} !== 2'b00) begin n_fail++; $display("FAIL done_pulse busy/done got=%b exp=00", {bus.busy, bus.done}); end
        n_checks++; if (bus.result !== 64'd8) begin n_fail++; $display("FAIL result_hold got=%h exp=8", bus.result); end
    endtask

    // Vectors: {a, b, sub, expected result, expected NZCV}
    task automatic test_sub_and_overflow();
        logic [W-1:0] va [6], vb [6], vr [6];
        logic         vs [6];
        logic [3:0]   vf [6];
        int lat, bc;
        va[0] = 64'd3;                  vb[0] = 64'd5; vs[0] = 1'b1; vr[0] = 64'hFFFF_FFFF_FFFF_FFFE; vf[0] = 4'b1000;
        va[1] = 64'd7;                  vb[1] = 64'd7; vs[1] = 1'b1; vr[1] = 64'h0;                   vf[1] = 4'b0110;
        va[2] = 64'h7FFF_FFFF_FFFF_FFFF; vb[2] = 64'd1; vs[2] = 1'b0; vr[2] = 64'h8000_0000_0000_0000; vf[2] = 4'b1001;
        va[3] = 64'hFFFF_FFFF_FFFF_FFFF; vb[3] = 64'd1; vs[3] = 1'b0; vr[3] = 64'h0;                   vf[3] = 4'b0110;
        va[4] = 64'h8000_0000_0000_0000; vb[4] = 64'd1; vs[4] = 1'b1; vr[4] = 64'h7FFF_FFFF_FFFF_FFFF; vf[4] = 4'b0011;
        va[5] = 64'h0123_4567_89AB_CDEF; vb[5] = 64'h1111_1111_1111_1111; vs[5] = 1'b0;
        vr[5] = 64'h1234_5678_9ABC_DF00; vf[5] = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            run_op(va[k], vb[k], vs[k], lat, bc);
            n_checks++; if (lat !== 64) begin n_fail++; $display("FAIL vec%0d_latency got=%0d exp=64", k, lat); end
            n_checks++; if (bus.result !== vr[k]) begin n_fail++; $display("FAIL vec%0d_result got=%h exp=%h", k, bus.result, vr[k]); end
            n_checks++; if (flags !== (vf[k] & FMASK)) begin n_fail++; $display("FAIL vec%0d_flags got=%b exp=%b", k, flags, vf[k] & FMASK); end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        bus.a = 64'd5; bus.b = 64'd3; bus.sub = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (i == 10) begin
                bus.start = 1'b1; bus.a = 64'd100; bus.b = 64'd40; bus.sub = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin lat = i; break; end
        end
        n_checks++; if (lat !== 64) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=64", lat); end
        n_checks++; if (bus.result !== 64'd8) begin n_fail++; $display("FAIL ignore_result got=%h exp=8", bus.result); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, lat, bc);
        n_checks++; if (bus.result !== 64'h1234_5678_9ABC_DF00) begin n_fail++; $display("FAIL b2b_first got=%h exp=123456789abcdf00", bus.result); end
        bus.a = 64'h8000_0000_0000_0000; bus.b = 64'd1; bus.sub = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept busy got=%b exp=1", bus.busy); end
        n_checks++; if (bus.result !== 64'h1234_5678_9ABC_DF00) begin n_fail++; $display("FAIL b2b_hold got=%h exp=123456789abcdf00", bus.result); end
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin lat = i + 1; break; end
        end
        n_checks++; if (lat !== 65) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=65", lat); end
        n_checks++; if (bus.result !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL b2b_second got=%h exp=7fffffffffffffff", bus.result); end
        n_checks++; if (flags !== (4'b0011 & FMASK)) begin n_fail++; $display("FAIL b2b_flags got=%b exp=%b", flags, 4'b0011 & FMASK); end
    endtask

    task automatic test_reset_abort();
        int saw_done;
        @(negedge clk);
        bus.a = 64'd9; bus.b = 64'd4; bus.sub = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", bus.done); end
        n_checks++; if (bus.result !== '0) begin n_fail++; $display("FAIL abort_result got=%h exp=0", bus.result); end
        n_checks++; if (flags !== 4'h0) begin n_fail++; $display("FAIL abort_flags got=%b exp=0000", flags); end
        reset = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) saw_done++;
        end
        n_checks++; if (saw_done !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", saw_done); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_and_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
